// File: rtl/pipe_stall_flush_ctrl_if.sv
// Control bundle between the pipeline stages and the central stall/flush controller.
// There is no valid/ready handshake: every signal is level-sensitive and sampled each cycle.
interface pipe_stall_flush_ctrl_if;
    logic        i_stallreq_if;
    logic        i_stallreq_id;
    logic        i_stallreq_ex;
    logic        i_stallreq_mem;
    logic [31:0] i_excepttype;
    logic [31:0] i_cp0_epc;
    logic        i_timeout_clr;
    logic [5:0]  o_stall;
    logic        o_flush;
    logic [31:0] o_new_pc;
    logic [31:0] o_stall_cycles;
    logic        o_stall_timeout;
    logic [0:0]  o_dbg_state;

    modport master (
        output i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        output i_excepttype, i_cp0_epc, i_timeout_clr,
        input  o_stall, o_flush, o_new_pc, o_stall_cycles, o_stall_timeout, o_dbg_state
    );

    modport slave (
        input  i_stallreq_if, i_stallreq_id, i_stallreq_ex, i_stallreq_mem,
        input  i_excepttype, i_cp0_epc, i_timeout_clr,
        output o_stall, o_flush, o_new_pc, o_stall_cycles, o_stall_timeout, o_dbg_state
    );
endinterface

// File: rtl/pipe_stall_flush_ctrl.sv
// Central stall/flush controller for the 6-stage core: stall vector, exception
// flush/redirect with a post-flush hold window, stall-cycle counter and watchdog.
module pipe_stall_flush_ctrl #(
    parameter int          FLUSH_HOLD    = 2,
    parameter int          STALL_TIMEOUT = 1024,
    parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    pipe_stall_flush_ctrl_if.slave bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int              HOLD_LOAD = (FLUSH_HOLD < 1) ? 1 : FLUSH_HOLD;
    localparam int              HW        = $clog2(HOLD_LOAD + 1);
    localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_LOAD);
    localparam logic [31:0]     WD_LAST   = (STALL_TIMEOUT < 1) ? 32'd0 : 32'(STALL_TIMEOUT - 1);

    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [31:0]   stall_cycles;
    logic [31:0]   wd_cnt;
    logic          timeout_flag;

    logic [5:0]    stall_req;
    logic [5:0]    stall_vec;
    logic          exc_take;
    logic [31:0]   exc_pc;
    logic          stalled;

    always_comb begin
        stall_req = 6'b000000;
        if (bus.i_stallreq_mem)     stall_req = 6'b011111;
        else if (bus.i_stallreq_ex) stall_req = 6'b001111;
        else if (bus.i_stallreq_id) stall_req = 6'b000111;
        else if (bus.i_stallreq_if) stall_req = 6'b000011;

        exc_pc = EXC_VECTOR;
        case (bus.i_excepttype)
            32'h0000_0001: exc_pc = INT_VECTOR;
            32'h0000_000e: exc_pc = bus.i_cp0_epc;
            default:       exc_pc = EXC_VECTOR;
        endcase
    end

    // Outputs are gated by reset so a stage register never sees a stale request while held in reset.
    assign exc_take  = i_rst_n && (state == ST_RUN) && (bus.i_excepttype != 32'd0);
    assign stall_vec = (i_rst_n && !exc_take) ? stall_req : 6'b000000;
    assign stalled   = (stall_vec != 6'b000000);

    assign bus.o_stall         = stall_vec;
    assign bus.o_flush         = exc_take;
    assign bus.o_new_pc        = exc_take ? exc_pc : 32'd0;
    assign bus.o_stall_cycles  = stall_cycles;
    assign bus.o_stall_timeout = timeout_flag;
    assign bus.o_dbg_state     = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
        end else if (exc_take) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_INIT;
        end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) state <= ST_RUN;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cycles <= 32'd0;
        end else if (stalled && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

    // The counter parks at the last value once the flag is up, so it cannot wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt       <= 32'd0;
            timeout_flag <= 1'b0;
        end else if (bus.i_timeout_clr) begin
            wd_cnt       <= 32'd0;
            timeout_flag <= 1'b0;
        end else if (!stalled) begin
            wd_cnt <= 32'd0;
        end else if (wd_cnt >= WD_LAST) begin
            wd_cnt       <= WD_LAST;
            timeout_flag <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipe_stall_flush_ctrl.sv
// Directed bench for pipe_stall_flush_ctrl (FLUSH_HOLD=2, STALL_TIMEOUT=8).
module tb_pipe_stall_flush_ctrl;
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  string       tag_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  pipe_stall_flush_ctrl_if bus ();

  pipe_stall_flush_ctrl #(
    .FLUSH_HOLD   (2),
    .STALL_TIMEOUT(8),
    .INT_VECTOR   (32'h0000_0020),
    .EXC_VECTOR   (32'h0000_0040)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    tag_q.push_back(tag);
    obs_q.push_back(obs);
    exp_q.push_back(exp);
  endtask

  task automatic set_req(input logic r_if, input logic r_id, input logic r_ex, input logic r_mem);
    bus.i_stallreq_if  = r_if;
    bus.i_stallreq_id  = r_id;
    bus.i_stallreq_ex  = r_ex;
    bus.i_stallreq_mem = r_mem;
  endtask

  // One exception accepted in RUN, then the 2-cycle hold window is let run out.
  task automatic do_exc(input string tag, input logic [31:0] code, input logic [31:0] exp_pc);
    bus.i_excepttype = code;
    #1;
    chk({tag, "_flush"}, bus.o_flush, 1'b1);
    chk({tag, "_pc"}, bus.o_new_pc, exp_pc);
    cyc();
    bus.i_excepttype = 32'd0;
    cyc();
    cyc();
    chk({tag, "_back_run"}, bus.o_dbg_state, RUN);
  endtask

  initial begin
    string       t;
    logic [31:0] o;
    logic [31:0] e;

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.i_excepttype  = 32'd0;
    bus.i_cp0_epc     = 32'd0;
    bus.i_timeout_clr = 1'b0;
    #1;
    chk("rst_stall", bus.o_stall, 6'h00);
    chk("rst_flush", bus.o_flush, 1'b0);
    chk("rst_new_pc", bus.o_new_pc, 32'd0);
    chk("rst_cycles", bus.o_stall_cycles, 32'd0);
    chk("rst_timeout", bus.o_stall_timeout, 1'b0);
    chk("rst_state", bus.o_dbg_state, RUN);
    #19;
    rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_stall", bus.o_stall, 6'h00);
      chk("idle_flush", bus.o_flush, 1'b0);
    end
    chk("idle_cycles", bus.o_stall_cycles, 32'd0);

    // stall priority encoding
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      chk("stall_mem", bus.o_stall, 6'b011111);
      cyc();
    end
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("stall_ex", bus.o_stall, 6'b001111);
    cyc();
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_id", bus.o_stall, 6'b000111);
    cyc();
    set_req(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_if", bus.o_stall, 6'b000011);
    cyc();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("stall_none", bus.o_stall, 6'b000000);
    chk("cycles_6", bus.o_stall_cycles, 32'd6);
    chk("no_timeout_6", bus.o_stall_timeout, 1'b0);
    cyc();

    // interrupt beats a mem stall, then follow-on exceptions are masked for 2 cycles
    bus.i_excepttype = 32'h1;
    set_req(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("int_flush", bus.o_flush, 1'b1);
    chk("int_stall", bus.o_stall, 6'b000000);
    chk("int_pc", bus.o_new_pc, 32'h0000_0020);
    cyc();
    bus.i_excepttype = 32'h8;
    set_req(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("hold1_flush", bus.o_flush, 1'b0);
    chk("hold1_new_pc", bus.o_new_pc, 32'd0);
    chk("hold1_stall", bus.o_stall, 6'b000111);
    chk("hold1_state", bus.o_dbg_state, HOLD);
    cyc();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold2_flush", bus.o_flush, 1'b0);
    cyc();
    chk("hold_end_flush", bus.o_flush, 1'b1);
    chk("hold_end_pc", bus.o_new_pc, 32'h0000_0040);
    cyc();
    bus.i_excepttype = 32'd0;
    cyc();
    cyc();
    chk("after_hold_state", bus.o_dbg_state, RUN);

    // redirect targets for the remaining code classes
    bus.i_cp0_epc = 32'h0000_1234;
    do_exc("eret", 32'he, 32'h0000_1234);
    do_exc("exc_a", 32'ha, 32'h0000_0040);
    do_exc("exc_d", 32'hd, 32'h0000_0040);
    do_exc("exc_other", 32'h5, 32'h0000_0040);
    do_exc("exc_high", 32'h8000_0000, 32'h0000_0040);
    chk("cycles_7", bus.o_stall_cycles, 32'd7);

    // watchdog: flag rises after the 8th stalled cycle and is sticky
    set_req(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) cyc();
    chk("wd_7_low", bus.o_stall_timeout, 1'b0);
    cyc();
    chk("wd_8_high", bus.o_stall_timeout, 1'b1);
    repeat (2) cyc();
    chk("wd_still_high", bus.o_stall_timeout, 1'b1);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("wd_sticky", bus.o_stall_timeout, 1'b1);
    bus.i_timeout_clr = 1'b1;
    cyc();
    bus.i_timeout_clr = 1'b0;
    chk("wd_cleared", bus.o_stall_timeout, 1'b0);

    // a single unstalled cycle restarts the count
    set_req(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) cyc();
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    set_req(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (7) cyc();
    chk("wd_gap_low", bus.o_stall_timeout, 1'b0);
    cyc();
    chk("wd_gap_high", bus.o_stall_timeout, 1'b1);
    // clear wins while still stalled
    bus.i_timeout_clr = 1'b1;
    cyc();
    bus.i_timeout_clr = 1'b0;
    chk("wd_clr_prio", bus.o_stall_timeout, 1'b0);
    cyc();
    chk("wd_after_clr", bus.o_stall_timeout, 1'b0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cycles_34", bus.o_stall_cycles, 32'd34);
    cyc();

    // reset in the middle of a hold window with stalls active
    bus.i_excepttype = 32'h1;
    #1;
    chk("pre_rst_flush", bus.o_flush, 1'b1);
    cyc();
    bus.i_excepttype = 32'd0;
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("pre_rst_stall", bus.o_stall, 6'b011111);
    chk("pre_rst_state", bus.o_dbg_state, HOLD);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", bus.o_stall, 6'h00);
    chk("mid_rst_flush", bus.o_flush, 1'b0);
    chk("mid_rst_new_pc", bus.o_new_pc, 32'd0);
    chk("mid_rst_cycles", bus.o_stall_cycles, 32'd0);
    chk("mid_rst_timeout", bus.o_stall_timeout, 1'b0);
    chk("mid_rst_state", bus.o_dbg_state, RUN);
    #2;
    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.i_excepttype = 32'hc;
    #1;
    chk("post_rst_flush", bus.o_flush, 1'b1);
    chk("post_rst_pc", bus.o_new_pc, 32'h0000_0040);
    cyc();
    bus.i_excepttype = 32'd0;
    chk("post_rst_hold", bus.o_dbg_state, HOLD);

    // scoreboard
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", t, o, e);
      end
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    if (fails == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
